// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared types and constants for the memory-stage controller:
//   FSM state type, REQ_CTRL target encodings, default data width
//   and the read data returned when an external access times out.
package mem_ctrl_pkg;

    localparam int unsigned DEFAULT_DATA_W = 48;

    // REQ_CTRL: 000 selects the local RAM, any other value is an external device id
    localparam logic [2:0] CTRL_RAM = 3'b000;

    localparam logic [47:0] BUS_ERR_DATA = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        RAM_ACC,
        EXT_WAIT,
        DONE
    } memState_t;

endpackage

// File: rtl/mem_ctrl_timeout.sv
// mem_ctrl_timeout
//   Loadable down-counter used to bound the external-bus ack wait.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     load        - load loadValue into the counter
//     clear       - force the counter to zero (highest priority)
//     tick        - decrement by one (saturates at zero)
//     loadValue   - value loaded on load
//     expired     - counter is zero
module mem_ctrl_timeout #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] loadValue,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    always_comb expired = (count == '0);

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
//   Memory-stage controller downstream of the CPU M stage. Routes each
//   request to the local data RAM (REQ_CTRL = 000) or to the external
//   peripheral bus (REQ_CTRL = device id), stalls the CPU clock gate via
//   WAIT_SIGNAL while the access is in flight, and releases it for one
//   DONE cycle at completion.
//   Optional feature: define MEM_CTRL_TIMEOUT_EN to bound the external ack
//   wait at TIMEOUT_CYCLES (timeout returns all-ones read data and sets ERR).
//   Ports:
//     CLK, RESET         - master clock, asynchronous active-low reset
//     REQ_*              - registered M-stage request
//     RSP_RDATA          - read data, updated only by completed reads
//     WAIT_SIGNAL        - stall request to the CPU clock gate
//     ERR                - sticky misalignment / timeout error
//     RAM_*              - local synchronous RAM (1-cycle read latency)
//     EXT_*              - external peripheral bus
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned RAM_AW         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_VALID,
    input  logic              REQ_WE,
    input  logic [2:0]        REQ_CTRL,
    input  logic [DATA_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              WAIT_SIGNAL,
    output logic              ERR,
    output logic              RAM_WE,
    output logic [RAM_AW-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA,
    output logic              EXT_REQ,
    output logic              EXT_WE,
    output logic [2:0]        EXT_SEL,
    output logic [DATA_W-1:0] EXT_ADDR,
    output logic [DATA_W-1:0] EXT_WDATA,
    input  logic              EXT_ACK,
    input  logic [DATA_W-1:0] EXT_RDATA
);

    memState_t         state;
    logic              heldWe;
    logic [2:0]        heldCtrl;
    logic [DATA_W-1:0] heldAddr;
    logic [DATA_W-1:0] heldWdata;
    logic              misaligned;
    logic              timeoutHit;

    always_comb misaligned = (REQ_ADDR[1:0] != 2'b00);

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic toExpired;

    // Reloaded while idle; counts down once per EXT_WAIT cycle so it reaches
    // zero in the TIMEOUT_CYCLES-th waiting cycle.
    mem_ctrl_timeout #(
        .CNT_W(CNT_W)
    ) timeoutCnt (
        .clk      (CLK),
        .rst_n    (RESET),
        .load     (state == IDLE),
        .clear    ((state == EXT_WAIT) && EXT_ACK),
        .tick     (state == EXT_WAIT),
        .loadValue(CNT_W'(TIMEOUT_CYCLES - 1)),
        .expired  (toExpired)
    );

    always_comb timeoutHit = (state == EXT_WAIT) && toExpired;
`else
    localparam int unsigned unusedTimeoutCycles = TIMEOUT_CYCLES;

    always_comb timeoutHit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            heldWe    <= 1'b0;
            heldCtrl  <= '0;
            heldAddr  <= '0;
            heldWdata <= '0;
            RSP_RDATA <= '0;
            ERR       <= 1'b0;
            EXT_REQ   <= 1'b0;
            RAM_WE    <= 1'b0;
        end else begin
            RAM_WE <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        heldWe    <= REQ_WE;
                        heldCtrl  <= REQ_CTRL;
                        heldAddr  <= REQ_ADDR;
                        heldWdata <= REQ_WDATA;
                        if (misaligned) begin
                            ERR   <= 1'b1;
                            state <= DONE;
                        end else if (REQ_CTRL == CTRL_RAM) begin
                            RAM_WE <= REQ_WE;
                            state  <= RAM_ACC;
                        end else begin
                            EXT_REQ <= 1'b1;
                            state   <= EXT_WAIT;
                        end
                    end
                end
                RAM_ACC: begin
                    if (!heldWe) begin
                        RSP_RDATA <= RAM_RDATA;
                    end
                    state <= DONE;
                end
                EXT_WAIT: begin
                    if (EXT_ACK) begin
                        if (!heldWe) begin
                            RSP_RDATA <= EXT_RDATA;
                        end
                        EXT_REQ <= 1'b0;
                        state   <= DONE;
                    end else if (timeoutHit) begin
                        if (!heldWe) begin
                            RSP_RDATA <= DATA_W'(BUS_ERR_DATA);
                        end
                        ERR     <= 1'b1;
                        EXT_REQ <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The RAM has a 1-cycle read latency, so the address is presented straight
    // from the request while idle; RAM_RDATA is then valid during RAM_ACC.
    always_comb begin
        RAM_ADDR  = (state == IDLE) ? REQ_ADDR[RAM_AW+1:2] : heldAddr[RAM_AW+1:2];
        RAM_WDATA = heldWdata;
        EXT_WE    = heldWe;
        EXT_SEL   = heldCtrl;
        EXT_ADDR  = heldAddr;
        EXT_WDATA = heldWdata;
    end

    always_comb begin
        WAIT_SIGNAL = ((state == IDLE) && REQ_VALID) || (state == RAM_ACC) || (state == EXT_WAIT);
    end

endmodule
